// File: rtl/param_cache.sv
// Direct-mapped, read-only parameter cache with in-order block refill,
// deferred flush and saturating hit/miss statistics.
module param_cache #(
  parameter int ADDR_W      = 16,
  parameter int WORD_W      = 32,
  parameter int LINES       = 64,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP  = 2'd1;
  localparam logic [1:0] S_FILL    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [WORD_W-1:0] r_data [LINES*BLOCK_WORDS];
  logic [OFF_W-1:0]  r_beat;
  logic              r_flush_pend;
  logic              r_rvalid;
  logic              r_hit;
  logic [WORD_W-1:0] r_rdata;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_last_beat;
  logic              w_fill_we;
  logic [WORD_W-1:0] w_resp_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_off       = r_addr[OFF_W-1:0];
  assign w_idx       = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag       = r_addr[ADDR_W-1:OFF_W+IDX_W];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last_beat = &r_beat;
  assign w_fill_we   = (r_state == S_FILL) && mem_valid;
  // On the last beat the requested word may be the one arriving right now.
  assign w_resp_word = (w_off == r_beat) ? mem_rdata : r_data[{w_idx, w_off}];

  assign cpu_ready  = (r_state == S_IDLE) && !flush && !r_flush_pend;
  assign cpu_rvalid = r_rvalid;
  assign cpu_rdata  = r_rdata;
  assign cpu_hit    = r_hit;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[{w_idx, r_beat}] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_we && w_last_beat) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_valid      <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_rvalid     <= 1'b0;
      r_hit        <= 1'b0;
      r_rdata      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      if (r_state != S_IDLE && flush) begin
        r_flush_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // A deferred flush is honoured before any new request is taken.
          if (flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_rvalid  <= 1'b1;
            r_hit     <= 1'b1;
            r_rdata   <= r_data[{w_idx, w_off}];
            r_hit_cnt <= sat_inc(r_hit_cnt);
            r_state   <= S_IDLE;
          end else begin
            r_miss_cnt <= sat_inc(r_miss_cnt);
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_beat     <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_valid) begin
            if (w_last_beat) begin
              r_valid[w_idx] <= 1'b1;
              r_mem_req      <= 1'b0;
              r_beat         <= '0;
              r_rvalid       <= 1'b1;
              r_hit          <= 1'b0;
              r_rdata        <= w_resp_word;
              r_state        <= S_RESPOND;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
